cla_seq_ctrl: RTL and testbench

Nibble-serial multi-precision adder controller. It sequences a single 4-bit carry-lookahead slice over WIDTH/4 cycles to add WIDTH-bit operands. A registered inter-nibble carry links the cycles. It sits between a requester and a consumer using valid/ready handshakes on input and output, so wide adds run on minimal adder hardware.

---
 rtl/cla_seq_ctrl.sv | 137 +++++++++++++
 tb/tb_cla_seq_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/cla_seq_ctrl.sv
// Nibble-serial WIDTH-bit adder: one 4-bit carry-lookahead slice reused for WIDTH/4 cycles, optional subtract via CLA_SEQ_SUB_EN.
// Latency: result valid NIBBLES cycles after the input handshake edge; one operation in flight at a time.
// Backpressure: in_ready only in IDLE; DONE holds S/Cout/out_valid until out_ready.
module cla_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
`ifdef CLA_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [IDX_W+1:0] sh;
    logic [3:0]       a_nib, b_nib, g, p, sum;
    logic [4:0]       c;
    logic [WIDTH-1:0] b_in;
    logic             c_in;

    // Subtract folds into the same datapath: A + ~B + 1.
    always_comb begin
        b_in = B;
        c_in = Cin;
`ifdef CLA_SEQ_SUB_EN
        if (sub) begin
            b_in = ~B;
            c_in = 1'b1;
        end
`endif
    end

    // Two-level lookahead: every carry is a flat sum of products of G/P and carry_q.
    always_comb begin
        sh    = {idx_q, 2'b00};
        a_nib = a_q[sh +: 4];
        b_nib = b_q[sh +: 4];
        g     = a_nib & b_nib;
        p     = a_nib | b_nib;
        c[0]  = carry_q;
        c[1]  = g[0] | (p[0] & carry_q);
        c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
        c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & carry_q);
        c[4]  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & carry_q);
        sum   = a_nib ^ b_nib ^ c[3:0];
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = b_in;
                    carry_d = c_in;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d[sh +: 4] = sum;
                carry_d      = c[4];
                idx_d        = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    cout_d  = c[4];
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign S         = s_q;
    assign Cout      = cout_q;

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// Bench for cla_seq_ctrl (WIDTH=16): directed and random operations checked against an integer-arithmetic model.
module tb_cla_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        Cin;
    logic        sub;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] S;
    logic        Cout;

    int n_assert = 0;
    int n_fail   = 0;

    cla_seq_ctrl #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
`ifdef CLA_SEQ_SUB_EN
        .sub       (sub),
`endif
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .Cout      (Cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {Cout, S} is the plain (WIDTH+1)-bit sum.
    function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sb);
        if (sb) return {1'b0, a} + {1'b0, ~b} + 17'd1;
        return {1'b0, a} + {1'b0, b} + {16'd0, cin};
    endfunction

    task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                            input logic cin, input logic sb);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        if (!in_ready) chk("in_ready_wait", in_ready, 1);
        in_valid = 1'b1;
        A = a; B = b; Cin = cin; sub = sb;
        @(posedge clk); #1;
        in_valid = 1'b0;
        A   = 16'($urandom);
        B   = 16'($urandom);
        Cin = 1'($urandom);
        sub = 1'($urandom);
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sb, input int hold);
        logic [16:0] e;
        int lat;
        e = model(a, b, cin, sb);
        start_op(a, b, cin, sb);
        lat = 0;
        while (!out_valid && lat < 20) begin
            chk("in_ready_busy", in_ready, 0);
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, 4);
        chk("S", S, e[15:0]);
        chk("Cout", Cout, e[16]);
        chk("busy_done", busy, 1);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom);
            A = 16'($urandom);
            B = 16'($urandom);
            @(posedge clk); #1;
            chk("hold_S", S, e[15:0]);
            chk("hold_Cout", Cout, e[16]);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_out_valid", out_valid, 0);
        chk("release_in_ready", in_ready, 1);
    endtask

    initial begin
        logic [16:0] e1, e2;
        int acc [2];
        int n, k, w;
        logic seen1;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; Cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_S", S, 0);
        chk("rst_Cout", Cout, 0);
        rst = 1'b0;

        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        run_op(16'h1234, 16'h4321, 1'b1, 1'b0, 3);

        // Reset in the middle of RUN, then rst together with in_valid in IDLE.
        start_op(16'h8000, 16'h8000, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        chk("midrst_S", S, 0);
        chk("midrst_Cout", Cout, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        chk("rst_vs_valid_busy", busy, 0);
        rst = 1'b0; in_valid = 1'b0;
        run_op(16'h0003, 16'h0004, 1'b0, 1'b0, 0);

        // Back-to-back with in_valid held and out_ready tied high.
        e1 = model(16'hABCD, 16'h1111, 1'b0, 1'b0);
        e2 = model(16'h7FFF, 16'h0001, 1'b1, 1'b0);
        A = 16'hABCD; B = 16'h1111; Cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        n = 0; k = 0; seen1 = 1'b0;
        acc[0] = 0; acc[1] = 0;
        while (n < 2 && k < 40) begin
            if (in_ready) begin
                acc[n] = k;
                n++;
            end
            if (out_valid && !seen1) begin
                seen1 = 1'b1;
                chk("b2b_S1", S, e1[15:0]);
                chk("b2b_Cout1", Cout, e1[16]);
            end
            @(posedge clk); #1;
            if (n == 1) begin
                A = 16'h7FFF; B = 16'h0001; Cin = 1'b1;
            end
            k++;
        end
        chk("b2b_accepts", n, 2);
        chk("b2b_spacing", acc[1] - acc[0], 6);
        chk("b2b_first_seen", seen1, 1);
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        chk("b2b_S2", S, e2[15:0]);
        chk("b2b_Cout2", Cout, e2[16]);
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("b2b_idle", in_ready, 1);

        for (int i = 0; i < 20; i++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'b0, int'($urandom_range(0, 2)));
        end

`ifdef CLA_SEQ_SUB_EN
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
        run_op(16'h0007, 16'h0005, 1'b1, 1'b1, 0);
        for (int i = 0; i < 10; i++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
